// File: rtl/core_seq.sv
// ---------------------------------------------------------------------------
// core_seq : multi-cycle instruction sequencer for the rvseed datapath.
//
// Each instruction walks FETCH -> EXEC -> (MEM) -> WB over handshaked
// instruction and data buses. The block latches the fetched instruction and
// the load data, drives the pc_reg advance pulse, qualifies the register-file
// write, and counts retired instructions. A bus that withholds its grant for
// more than TIMEOUT_CYCLES cycles parks the core in a terminal error state.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   run_en                  core may run; stops at the next instruction boundary
//   curr_pc                 current PC from pc_reg
//   is_load, is_store       decode of the current instruction (store wins if both)
//   alu_res, reg2_rdata     effective address / store data for MEM
//   ibus_req/addr/gnt/rdata instruction fetch bus (rdata valid with gnt)
//   dbus_req/we/addr/wdata/gnt/rdata  data bus (rdata valid with gnt)
//   inst, load_data         latched instruction and load data
//   pc_ena, reg_wen_gate    one-cycle pulses during WB
//   busy                    state is neither IDLE nor ERR
//   bus_err                 sticky grant-timeout error
//   retire_cnt              retired instruction count (wraps)
// ---------------------------------------------------------------------------
module core_seq #(
  parameter int CPU_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_en,
  input  logic [CPU_WIDTH-1:0] curr_pc,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [CPU_WIDTH-1:0] alu_res,
  input  logic [CPU_WIDTH-1:0] reg2_rdata,
  output logic                 ibus_req,
  output logic [CPU_WIDTH-1:0] ibus_addr,
  input  logic                 ibus_gnt,
  input  logic [CPU_WIDTH-1:0] ibus_rdata,
  output logic                 dbus_req,
  output logic                 dbus_we,
  output logic [CPU_WIDTH-1:0] dbus_addr,
  output logic [CPU_WIDTH-1:0] dbus_wdata,
  input  logic                 dbus_gnt,
  input  logic [CPU_WIDTH-1:0] dbus_rdata,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] load_data,
  output logic                 pc_ena,
  output logic                 reg_wen_gate,
  output logic                 busy,
  output logic                 bus_err,
  output logic [31:0]          retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TO_WIDTH-1:0] TO_MAX   = {TO_WIDTH{1'b1}};
  localparam logic [TO_WIDTH-1:0] TO_ZERO  = {TO_WIDTH{1'b0}};
  localparam logic [TO_WIDTH-1:0] TO_ONE   = {{(TO_WIDTH-1){1'b0}}, 1'b1};
  localparam logic                TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TO_WIDTH-1:0]  r_to_cnt;
  logic                 w_to_expired;
  logic                 w_waiting;
  logic                 w_fetch_first;

  logic                 r_ibus_req;
  logic [CPU_WIDTH-1:0] r_ibus_addr;
  logic                 r_dbus_req;
  logic                 r_dbus_we;
  logic [CPU_WIDTH-1:0] r_dbus_addr;
  logic [CPU_WIDTH-1:0] r_dbus_wdata;
  logic [CPU_WIDTH-1:0] r_inst;
  logic [CPU_WIDTH-1:0] r_load_data;
  logic                 r_pc_ena;
  logic                 r_reg_wen_gate;
  logic                 r_busy;
  logic                 r_bus_err;
  logic [31:0]          r_retire_cnt;

  assign w_to_expired  = TO_EN && (r_to_cnt == TO_LIMIT);
  assign w_waiting     = ((r_state == S_FETCH) && !ibus_gnt) ||
                         ((r_state == S_MEM)   && !dbus_gnt);
  // The counter is cleared on every state entry, so zero marks the first
  // FETCH cycle: the only cycle in which pc_reg may just have advanced.
  assign w_fetch_first = (r_state == S_FETCH) && (r_to_cnt == TO_ZERO);

  // Next-state decode; a grant beats a timeout that expires in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (run_en) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (ibus_gnt) begin
          w_state_nxt = S_EXEC;
        end else if (w_to_expired) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (dbus_gnt) begin
          w_state_nxt = S_WB;
        end else if (w_to_expired) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_MEM;
        end
      end
      S_WB: begin
        if (run_en) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_ERR;
    endcase
  end

  // Sequencer state, registered control outputs and datapath latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_to_cnt       <= TO_ZERO;
      r_ibus_req     <= 1'b0;
      r_ibus_addr    <= {CPU_WIDTH{1'b0}};
      r_dbus_req     <= 1'b0;
      r_dbus_we      <= 1'b0;
      r_dbus_addr    <= {CPU_WIDTH{1'b0}};
      r_dbus_wdata   <= {CPU_WIDTH{1'b0}};
      r_inst         <= {CPU_WIDTH{1'b0}};
      r_load_data    <= {CPU_WIDTH{1'b0}};
      r_pc_ena       <= 1'b0;
      r_reg_wen_gate <= 1'b0;
      r_busy         <= 1'b0;
      r_bus_err      <= 1'b0;
      r_retire_cnt   <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      // Control outputs are registered images of the next state.
      r_ibus_req     <= (w_state_nxt == S_FETCH);
      r_dbus_req     <= (w_state_nxt == S_MEM);
      r_pc_ena       <= (w_state_nxt == S_WB);
      r_reg_wen_gate <= (w_state_nxt == S_WB);
      r_busy         <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
      r_bus_err      <= (w_state_nxt == S_ERR);

      if (w_state_nxt != r_state) begin
        r_to_cnt <= TO_ZERO;
      end else if (w_waiting && (r_to_cnt != TO_MAX)) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end else begin
        r_to_cnt <= r_to_cnt;
      end

      case (r_state)
        S_IDLE: begin
          if (run_en) begin
            r_ibus_addr <= curr_pc;
          end
        end
        S_FETCH: begin
          if (w_fetch_first) begin
            r_ibus_addr <= curr_pc;
          end
          if (ibus_gnt) begin
            r_inst <= ibus_rdata;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) begin
            r_dbus_addr  <= alu_res;
            r_dbus_wdata <= reg2_rdata;
            r_dbus_we    <= is_store;
          end
        end
        S_MEM: begin
          if (dbus_gnt) begin
            r_load_data <= dbus_rdata;
          end
        end
        S_WB: begin
          r_retire_cnt <= r_retire_cnt + 32'd1;
        end
        default: begin
          r_retire_cnt <= r_retire_cnt;
        end
      endcase
    end
  end

  // In the first FETCH cycle after WB, pc_reg has only just advanced, so the
  // live PC is forwarded until the latched copy catches up one cycle later.
  assign ibus_addr    = w_fetch_first ? curr_pc : r_ibus_addr;
  assign ibus_req     = r_ibus_req;
  assign dbus_req     = r_dbus_req;
  assign dbus_we      = r_dbus_we;
  assign dbus_addr    = r_dbus_addr;
  assign dbus_wdata   = r_dbus_wdata;
  assign inst         = r_inst;
  assign load_data    = r_load_data;
  assign pc_ena       = r_pc_ena;
  assign reg_wen_gate = r_reg_wen_gate;
  assign busy         = r_busy;
  assign bus_err      = r_bus_err;
  assign retire_cnt   = r_retire_cnt;

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic [31:0] curr_pc;
  logic        is_load, is_store;
  logic [31:0] alu_res, reg2_rdata;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic [31:0] ibus_rdata;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_gnt;
  logic [31:0] dbus_rdata;
  logic [31:0] inst, load_data;
  logic        pc_ena, reg_wen_gate, busy, bus_err;
  logic [31:0] retire_cnt;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_retire;
  logic [31:0] exp_pc;

  core_seq #(.CPU_WIDTH(32), .TIMEOUT_CYCLES(4), .TO_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .curr_pc(curr_pc),
    .is_load(is_load), .is_store(is_store), .alu_res(alu_res), .reg2_rdata(reg2_rdata),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt), .ibus_rdata(ibus_rdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rdata(dbus_rdata), .inst(inst), .load_data(load_data),
    .pc_ena(pc_ena), .reg_wen_gate(reg_wen_gate), .busy(busy), .bus_err(bus_err),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // pc_reg stand-in: advances by one instruction on each pc_ena pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) curr_pc <= 32'd0;
    else if (pc_ena) curr_pc <= curr_pc + 32'd4;
  end

  task automatic randomize_inputs;
    run_en     = 1'($urandom);
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    alu_res    = $urandom;
    reg2_rdata = $urandom;
    ibus_gnt   = 1'($urandom);
    ibus_rdata = $urandom;
    dbus_gnt   = 1'($urandom);
    dbus_rdata = $urandom;
  endtask

  task automatic test_reset;
    logic [5:0] flg;
    rst_n = 1'b0;
    randomize_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flg = {ibus_req, dbus_req, pc_ena, reg_wen_gate, busy, bus_err};
      n_total++;
      if (flg !== 6'b0) $display("FAIL reset_flags: got %b want 000000", flg);
      else n_pass++;
      n_total++;
      if ({ibus_addr, dbus_addr, dbus_wdata, inst, load_data, retire_cnt, dbus_we} !== 193'd0)
        $display("FAIL reset_data: ibus_addr=%h dbus_addr=%h wdata=%h inst=%h load=%h retire=%h we=%b want all 0",
                 ibus_addr, dbus_addr, dbus_wdata, inst, load_data, retire_cnt, dbus_we);
      else n_pass++;
      randomize_inputs();
    end
    run_en = 1'b0; ibus_gnt = 1'b0; dbus_gnt = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    flg = {ibus_req, dbus_req, pc_ena, reg_wen_gate, busy, bus_err};
    n_total++;
    if (flg !== 6'b0) $display("FAIL idle_after_reset: got %b want 000000", flg);
    else n_pass++;
    exp_retire = 32'd0;
    exp_pc     = 32'd0;
  endtask

  // Runs one instruction from its first FETCH cycle. Expected cycle shape:
  // fw+1 fetch cycles, one EXEC, mw+1 MEM cycles if memory, one WB.
  task automatic do_instr(input logic [31:0] iw, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] rd, input int fw, input int mw,
                          input bit ld, input bit st, input bit drop);
    bit         mem;
    bit         in_mem;
    int         total;
    logic [5:0] ef, flg;
    mem   = ld | st;
    total = fw + 3 + (mem ? mw + 1 : 0);
    is_load = ld; is_store = st; alu_res = ad; reg2_rdata = wd;
    for (int k = 0; k < total; k++) begin
      in_mem = mem && (k >= fw + 2) && (k < total - 1);
      ef  = {(k <= fw), in_mem, (k == total - 1), (k == total - 1), 1'b1, 1'b0};
      flg = {ibus_req, dbus_req, pc_ena, reg_wen_gate, busy, bus_err};
      n_total++;
      if (flg !== ef) $display("FAIL cycle_flags k=%0d: got %b want %b", k, flg, ef);
      else n_pass++;
      if (k <= fw) begin
        n_total++;
        if (ibus_addr !== exp_pc) $display("FAIL ibus_addr k=%0d: got %h want %h", k, ibus_addr, exp_pc);
        else n_pass++;
      end
      if (k == fw + 1) begin
        n_total++;
        if (inst !== iw) $display("FAIL inst_latch: got %h want %h", inst, iw);
        else n_pass++;
      end
      if (in_mem) begin
        n_total++;
        if ({dbus_addr, dbus_wdata, dbus_we} !== {ad, wd, st})
          $display("FAIL dbus_fields k=%0d: got %h/%h/%b want %h/%h/%b",
                   k, dbus_addr, dbus_wdata, dbus_we, ad, wd, st);
        else n_pass++;
      end
      // Junk data except on the granting cycle; stray grants when req is low.
      ibus_gnt   = (k <= fw) ? (k == fw) : 1'($urandom);
      ibus_rdata = (k == fw) ? iw : $urandom;
      dbus_gnt   = in_mem ? (k == fw + 2 + mw) : 1'($urandom);
      dbus_rdata = (in_mem && k == fw + 2 + mw) ? rd : $urandom;
      if (drop && k == fw + 2) run_en = 1'b0;
      @(negedge clk);
    end
    exp_retire = exp_retire + 32'd1;
    exp_pc     = exp_pc + 32'd4;
    n_total++;
    if (retire_cnt !== exp_retire) $display("FAIL retire_cnt: got %0d want %0d", retire_cnt, exp_retire);
    else n_pass++;
    n_total++;
    if (inst !== iw) $display("FAIL inst_stable: got %h want %h", inst, iw);
    else n_pass++;
    if (mem) begin
      n_total++;
      if (load_data !== rd) $display("FAIL load_data: got %h want %h", load_data, rd);
      else n_pass++;
    end
    if (run_en) begin
      n_total++;
      if ({ibus_req, ibus_addr} !== {1'b1, exp_pc})
        $display("FAIL next_fetch: got req=%b addr=%h want req=1 addr=%h", ibus_req, ibus_addr, exp_pc);
      else n_pass++;
    end else begin
      n_total++;
      if ({busy, ibus_req} !== 2'b00) $display("FAIL stop_idle: got busy=%b req=%b want 0/0", busy, ibus_req);
      else n_pass++;
    end
    ibus_gnt = 1'b0;
    dbus_gnt = 1'b0;
  endtask

  task automatic test_first_addi;
    run_en = 1'b1;
    @(negedge clk);
    do_instr(32'h00500093, $urandom, $urandom, $urandom, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_wait;
    do_instr($urandom, 32'h00000100, $urandom, 32'hDEADBEEF, 0, 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_store;
    do_instr($urandom, $urandom, 32'h12345678, $urandom, 0, 0, 1'b0, 1'b1, 1'b0);
    do_instr($urandom, $urandom, $urandom, $urandom, 1, 1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_grant_at_limit;
    do_instr($urandom, $urandom, $urandom, $urandom, 4, 4, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++)
      do_instr($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
               1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid;
    is_load = 1'b1; is_store = 1'b0;
    ibus_gnt = 1'b1;
    @(negedge clk);
    ibus_gnt = 1'b0; dbus_gnt = 1'b0;
    @(negedge clk);
    n_total++;
    if (dbus_req !== 1'b1) $display("FAIL mid_mem_req: got %b want 1", dbus_req);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({ibus_req, dbus_req, busy, pc_ena, retire_cnt} !== 36'd0)
      $display("FAIL mid_reset_drop: got ireq=%b dreq=%b busy=%b pc_ena=%b retire=%0d want all 0",
               ibus_req, dbus_req, busy, pc_ena, retire_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_retire = 32'd0;
    exp_pc     = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_run_drop;
    do_instr($urandom, $urandom, $urandom, $urandom, 1, 1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ibus_gnt = 1'($urandom); dbus_gnt = 1'($urandom);
      @(negedge clk);
      n_total++;
      if ({ibus_req, busy, retire_cnt} !== {2'b00, exp_retire})
        $display("FAIL stays_idle: got req=%b busy=%b retire=%0d want 0/0/%0d", ibus_req, busy, retire_cnt, exp_retire);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    logic [5:0] flg;
    ibus_gnt = 1'b0; dbus_gnt = 1'b0;
    run_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      flg = {ibus_req, dbus_req, pc_ena, reg_wen_gate, busy, bus_err};
      n_total++;
      if (flg !== 6'b100010 || ibus_addr !== exp_pc)
        $display("FAIL fetch_wait k=%0d: got %b addr=%h want 100010 addr=%h", k, flg, ibus_addr, exp_pc);
      else n_pass++;
      ibus_gnt = 1'b0; dbus_gnt = 1'($urandom);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      flg = {ibus_req, dbus_req, pc_ena, reg_wen_gate, busy, bus_err};
      n_total++;
      if (flg !== 6'b000001 || retire_cnt !== exp_retire)
        $display("FAIL err_sticky i=%0d: got %b retire=%0d want 000001 retire=%0d", i, flg, retire_cnt, exp_retire);
      else n_pass++;
      randomize_inputs();
      @(negedge clk);
    end
  endtask

  task automatic test_recover;
    logic [5:0] flg;
    rst_n = 1'b0;
    run_en = 1'b0; ibus_gnt = 1'b0; dbus_gnt = 1'b0;
    #1;
    n_total++;
    if (bus_err !== 1'b0) $display("FAIL err_cleared: got %b want 0", bus_err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    flg = {ibus_req, dbus_req, pc_ena, reg_wen_gate, busy, bus_err};
    n_total++;
    if (flg !== 6'b0) $display("FAIL recover_idle: got %b want 000000", flg);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_addi();
    test_load_wait();
    test_store();
    test_grant_at_limit();
    test_random();
    test_reset_mid();
    test_run_drop();
    test_timeout();
    test_recover();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
Multi-cycle sequencer for the rvseed datapath. It replaces the single-cycle assumption with handshaked instruction and data buses. Each instruction runs through FETCH, EXEC, optional MEM and WB phases. The block drives the pc_reg enable, gates the register-file write, latches the instruction and load data, and counts retired instructions. It sits in the rvseed top between pc_reg, ctrl, alu, reg_file and the external memory buses.

Parameters:
CPU_WIDTH, 32, datapath/address width (matches `CPU_WIDTH)
TIMEOUT_CYCLES, 255, max wait cycles for a bus grant before error; 0 disables the timeout
TO_WIDTH, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2^TO_WIDTH

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
run_en  in  1  core may run; when low, the core stops at the next instruction boundary
curr_pc  in  CPU_WIDTH  current PC from pc_reg
is_load  in  1  ctrl decode: current inst is a load
is_store  in  1  ctrl decode: current inst is a store
alu_res  in  CPU_WIDTH  effective address for load/store
reg2_rdata  in  CPU_WIDTH  store data
ibus_req  out  1  instruction fetch request
ibus_addr  out  CPU_WIDTH  fetch address
ibus_gnt  in  1  fetch grant; ibus_rdata valid in the same cycle
ibus_rdata  in  CPU_WIDTH  fetched instruction
dbus_req  out  1  data request
dbus_we  out  1  1 = store, 0 = load
dbus_addr  out  CPU_WIDTH  data address
dbus_wdata  out  CPU_WIDTH  store data
dbus_gnt  in  1  data grant; dbus_rdata valid in the same cycle
dbus_rdata  in  CPU_WIDTH  load data
inst  out  CPU_WIDTH  latched instruction, feeds ctrl/imm_gen
load_data  out  CPU_WIDTH  latched load data
pc_ena  out  1  one-cycle PC advance pulse
reg_wen_gate  out  1  one-cycle register-file write qualifier
busy  out  1  state is neither IDLE nor ERR
bus_err  out  1  sticky timeout error
retire_cnt  out  32  retired instruction count

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, WB, ERR. State is registered. All req, pc_ena and reg_wen_gate outputs decode from the registered state, never from inputs.
- Reset (async, rst_n low):
  - state = IDLE.
  - inst, load_data, ibus_addr, dbus_addr, dbus_wdata, dbus_we, retire_cnt, timeout counter = 0.
  - All req, pc_ena, reg_wen_gate, busy, bus_err = 0.
  - Asserting reset mid-transaction drops any req immediately.
- IDLE: if run_en = 1, go to FETCH and latch ibus_addr <= curr_pc.
- FETCH: ibus_req = 1; ibus_addr is held stable.
  - If ibus_gnt = 1: inst <= ibus_rdata, go to EXEC.
  - If there is no grant and TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES: go to ERR.
- EXEC: one settle cycle for decode and ALU.
  - If is_load or is_store: go to MEM and latch dbus_addr <= alu_res, dbus_wdata <= reg2_rdata, dbus_we <= is_store.
  - Otherwise go to WB.
  - If is_load and is_store are both 1, the access is treated as a store.
- MEM: dbus_req = 1; address, data and we are held stable.
  - If dbus_gnt = 1: load_data <= dbus_rdata (for stores too; value is don't-care), go to WB.
  - Timeout applies as in FETCH.
- WB: pc_ena = 1 and reg_wen_gate = 1 for exactly this cycle; retire_cnt += 1, wrapping 0xFFFFFFFF -> 0.
  - Next state: FETCH (latching ibus_addr <= next value of curr_pc, i.e. the address pc_reg presents after the pc_ena edge) if run_en = 1, else IDLE.
  - Implementation: latch in FETCH's first cycle from curr_pc; ibus_addr must equal curr_pc for the whole FETCH.
- ERR: terminal until reset. All req = 0, bus_err = 1, busy = 0. run_en is ignored.
- Timeout counter: cleared on every state entry; increments each cycle in FETCH/MEM without a grant; saturates.
- Grants arriving while the matching req is low are ignored.
- run_en falling mid-instruction: the instruction completes through WB, then the core goes to IDLE. No partial retire.
- Latency with zero-wait grants: non-memory instruction 3 cycles (FETCH, EXEC, WB); load/store 4 cycles. Each wait cycle adds 1.
- inst stays stable from EXEC through the following FETCH grant, so ctrl outputs are valid in EXEC, MEM and WB.

Test Plan:
- Reset, then hold rst_n low 3 cycles with random bus inputs -> all outputs 0; state IDLE; retire_cnt = 0.
- run_en = 1, curr_pc = 0x0, ibus_gnt tied 1, inst = 0x00500093 (addi) -> ibus_addr = 0x0; inst latched next cycle; pc_ena/reg_wen_gate pulse in cycle 3; retire_cnt = 1; FETCH of the next PC in cycle 4.
- Load with alu_res = 0x100 and dbus_gnt delayed 2 cycles, dbus_rdata = 0xDEADBEEF -> dbus_req high 3 cycles, dbus_addr = 0x100 stable, dbus_we = 0; load_data = 0xDEADBEEF; WB in cycle 6.
- Store with reg2_rdata = 0x12345678, immediate grant -> dbus_we = 1, dbus_wdata = 0x12345678; 4-cycle instruction.
- run_en dropped during MEM -> instruction still retires (retire_cnt + 1), then IDLE, busy = 0, no further ibus_req.
- TIMEOUT_CYCLES = 4, ibus_gnt held 0 -> ERR after 5 FETCH cycles; bus_err = 1 sticky; ibus_req = 0; only rst_n recovers.
